// File: rtl/stream_serialize_pkg.sv
// Shared stream definitions: serializer FSM states and EOS flag encoding
// used by every stream block that carries an EOS bit in the token MSB.
package stream_serialize_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    EOS  = 2'd2
  } state_t;

  // Token MSB: 1 marks end-of-stream; an EOS token carries no data bits.
  localparam logic eos_flag  = 1'b1;
  localparam logic data_flag = 1'b0;

endpackage

// File: rtl/stream_serialize.sv
// Wide-to-narrow stream serializer: splits each wide token into ratio narrow
// words (word 0 first) and forwards a data-less EOS token for EOS input.
module stream_serialize
  import stream_serialize_pkg::*;
#(
  parameter int width    = 8,
  parameter int ratio    = 4,
  parameter int cntwidth = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ratio*width:0]     i_d,
  input  logic                     i_v,
  output logic                     i_b,
  output logic [width:0]           o_d,
  output logic                     o_v,
  input  logic                     o_b
);

  localparam int                  data_w     = ratio * width;
  localparam logic [cntwidth-1:0] last_count = cntwidth'(ratio - 1);

  state_t              state;
  logic [cntwidth-1:0] count;
  logic [data_w-1:0]   hold;

  logic                busy;
  logic                last;
  logic                out_xfer;
  logic                in_xfer;
  logic [cntwidth-1:0] next_idx;
  logic [width-1:0]    next_word;

  // i_b depends combinationally on o_b so a new token can enter on the same
  // edge the final word (or EOS) leaves, giving gap-free back-to-back tokens.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    busy      = (state != IDLE);
    last      = (state == EOS) || ((state == SEND) && (count == last_count));
    out_xfer  = o_v && !o_b;
    i_b       = busy && !(last && out_xfer);
    in_xfer   = i_v && !i_b;
    next_idx  = (count == last_count) ? '0 : count + 1'b1;
    next_word = hold[next_idx*width +: width];
  end

  // Outputs are registered; they only ever depend on state held here, so
  // there is no combinational path from i_d or i_v to any output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the hold register is reset too, so no stale token data survives a reset.
      state <= IDLE;
      count <= '0;
      hold  <= '0;
      o_d   <= '0;
      o_v   <= 1'b0;
    end else if (in_xfer) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      count <= '0;
      o_v   <= 1'b1;
      if (i_d[data_w] == eos_flag) begin
        state <= EOS;
        o_d   <= {eos_flag, {width{1'b0}}};
      end else begin
        state <= SEND;
        hold  <= i_d[data_w-1:0];
        o_d   <= {data_flag, i_d[width-1:0]};
      end
    end else if (out_xfer) begin
      if (last) begin
        state <= IDLE;
        count <= '0;
        o_d   <= '0;
        o_v   <= 1'b0;
      end else begin
        count <= next_idx;
        o_d   <= {data_flag, next_word};
      end
    end
  end

endmodule

// File: tb/tb_stream_serialize.sv
// Directed self-checking bench for stream_serialize (width=8, ratio=4).
module tb_stream_serialize;

  localparam int width    = 8;
  localparam int ratio    = 4;
  localparam int cntwidth = 4;

  logic                 clock;
  logic                 reset;
  logic [ratio*width:0] i_d;
  logic                 i_v;
  logic                 i_b;
  logic [width:0]       o_d;
  logic                 o_v;
  logic                 o_b;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [32:0] tok_a   = 33'h0_44332211;
  localparam logic [32:0] tok_b   = 33'h0_88776655;
  localparam logic [32:0] tok_eos = 33'h1_DEADBEEF;

  stream_serialize #(.width(width), .ratio(ratio), .cntwidth(cntwidth)) dut (
    .clock (clock),
    .reset (reset),
    .i_d   (i_d),
    .i_v   (i_v),
    .i_b   (i_b),
    .o_d   (o_d),
    .o_v   (o_v),
    .o_b   (o_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; i_v = 1'b0; o_b = 1'b0; i_d = '0;
    repeat (3) tick();
    n_cmp++; if (o_v !== 1'b0) begin n_bad++; $display("FAIL reset_o_v: got %b want 0", o_v); end
    n_cmp++; if (i_b !== 1'b0) begin n_bad++; $display("FAIL reset_i_b: got %b want 0", i_b); end
    n_cmp++; if (o_d !== 9'h000) begin n_bad++; $display("FAIL reset_o_d: got %h want 000", o_d); end
    reset = 1'b1;
    tick();
    n_cmp++; if (o_v !== 1'b0) begin n_bad++; $display("FAIL idle_o_v: got %b want 0", o_v); end
  endtask

  task automatic test_single();
    logic [8:0] exp_w [4] = '{9'h011, 9'h022, 9'h033, 9'h044};
    i_d = tok_a; i_v = 1'b1;
    n_cmp++; if (i_b !== 1'b0) begin n_bad++; $display("FAIL single_accept_i_b: got %b want 0", i_b); end
    tick();
    i_v = 1'b0; i_d = '0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (o_v !== 1'b1) begin n_bad++; $display("FAIL single_o_v[%0d]: got %b want 1", k, o_v); end
      n_cmp++; if (o_d !== exp_w[k]) begin n_bad++; $display("FAIL single_o_d[%0d]: got %h want %h", k, o_d, exp_w[k]); end
      tick();
    end
    n_cmp++; if (o_v !== 1'b0) begin n_bad++; $display("FAIL single_end_o_v: got %b want 0", o_v); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_w [8] = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066, 9'h077, 9'h088};
    i_d = tok_a; i_v = 1'b1;
    tick();
    i_d = tok_b;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (o_v !== 1'b1) begin n_bad++; $display("FAIL b2b_o_v[%0d]: got %b want 1", k, o_v); end
      n_cmp++; if (o_d !== exp_w[k]) begin n_bad++; $display("FAIL b2b_o_d[%0d]: got %h want %h", k, o_d, exp_w[k]); end
      if (k < 3) begin
        n_cmp++; if (i_b !== 1'b1) begin n_bad++; $display("FAIL b2b_i_b[%0d]: got %b want 1", k, i_b); end
      end else if (k == 3) begin
        n_cmp++; if (i_b !== 1'b0) begin n_bad++; $display("FAIL b2b_i_b_last: got %b want 0", i_b); end
      end
      tick();
      if (k == 3) begin i_v = 1'b0; i_d = '0; end
    end
    n_cmp++; if (o_v !== 1'b0) begin n_bad++; $display("FAIL b2b_end_o_v: got %b want 0", o_v); end
  endtask

  task automatic test_stall();
    i_d = tok_a; i_v = 1'b1;
    tick();
    i_v = 1'b0; i_d = '0;
    tick();
    n_cmp++; if (o_d !== 9'h022) begin n_bad++; $display("FAIL stall_pre_o_d: got %h want 022", o_d); end
    o_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (o_d !== 9'h022) begin n_bad++; $display("FAIL stall_o_d[%0d]: got %h want 022", k, o_d); end
      n_cmp++; if (o_v !== 1'b1) begin n_bad++; $display("FAIL stall_o_v[%0d]: got %b want 1", k, o_v); end
      n_cmp++; if (i_b !== 1'b1) begin n_bad++; $display("FAIL stall_i_b[%0d]: got %b want 1", k, i_b); end
    end
    o_b = 1'b0;
    tick();
    n_cmp++; if (o_d !== 9'h033) begin n_bad++; $display("FAIL stall_resume_o_d: got %h want 033", o_d); end
    tick();
    n_cmp++; if (o_d !== 9'h044) begin n_bad++; $display("FAIL stall_tail_o_d: got %h want 044", o_d); end
    tick();
    n_cmp++; if (o_v !== 1'b0) begin n_bad++; $display("FAIL stall_end_o_v: got %b want 0", o_v); end
  endtask

  task automatic test_eos();
    i_d = tok_eos; i_v = 1'b1;
    tick();
    i_v = 1'b0; i_d = '0;
    n_cmp++; if (o_d !== 9'h100) begin n_bad++; $display("FAIL eos_o_d: got %h want 100", o_d); end
    n_cmp++; if (o_v !== 1'b1) begin n_bad++; $display("FAIL eos_o_v: got %b want 1", o_v); end
    tick();
    n_cmp++; if (o_v !== 1'b0) begin n_bad++; $display("FAIL eos_end_o_v: got %b want 0", o_v); end
    // EOS offered on the edge where the final data word leaves.
    i_d = tok_a; i_v = 1'b1;
    tick();
    i_v = 1'b0; i_d = '0;
    repeat (3) tick();
    n_cmp++; if (o_d !== 9'h044) begin n_bad++; $display("FAIL eos_b2b_last_o_d: got %h want 044", o_d); end
    i_d = tok_eos; i_v = 1'b1;
    n_cmp++; if (i_b !== 1'b0) begin n_bad++; $display("FAIL eos_b2b_i_b: got %b want 0", i_b); end
    tick();
    i_v = 1'b0; i_d = '0;
    n_cmp++; if (o_d !== 9'h100) begin n_bad++; $display("FAIL eos_b2b_o_d: got %h want 100", o_d); end
    n_cmp++; if (o_v !== 1'b1) begin n_bad++; $display("FAIL eos_b2b_o_v: got %b want 1", o_v); end
    tick();
    n_cmp++; if (o_v !== 1'b0) begin n_bad++; $display("FAIL eos_b2b_end_o_v: got %b want 0", o_v); end
  endtask

  task automatic test_reset_mid();
    i_d = tok_a; i_v = 1'b1;
    tick();
    i_v = 1'b0; i_d = '0;
    tick();
    n_cmp++; if (o_d !== 9'h022) begin n_bad++; $display("FAIL rmid_pre_o_d: got %h want 022", o_d); end
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (o_v !== 1'b0) begin n_bad++; $display("FAIL rmid_o_v: got %b want 0", o_v); end
    n_cmp++; if (o_d !== 9'h000) begin n_bad++; $display("FAIL rmid_o_d: got %h want 000", o_d); end
    n_cmp++; if (i_b !== 1'b0) begin n_bad++; $display("FAIL rmid_i_b: got %b want 0", i_b); end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (o_v !== 1'b0) begin n_bad++; $display("FAIL rmid_after_o_v[%0d]: got %b want 0 (o_d %h)", k, o_v, o_d); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_eos();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
